datapath_mem_responder: RTL and testbench
=========================================

// Module: datapath_mem_responder
// PURPOSE
//  Responder (cache/memory end) of datapath_cache_if: serves the datapath's instruction and data requests.
//  Arbitrates imem/dmem requests onto a single-ported word RAM, then returns ihit/dhit with load data.
//  Sits between the datapath and the RAM model.
//  Has a watchdog for hung RAM accesses.
// PARAMETERS
//  TIMEOUT   64  max cycles from RAM issue to ram_ack before abort (>=2)
//  CNT_W     7   watchdog counter width, must hold TIMEOUT
// PORTS
//  CLK        in   1   clock, rising edge
//  RST        in   1   asynchronous, active-high reset
//  imemREN    in   1   instruction fetch request, held until ihit
//  imemaddr   in   32  fetch byte address
//  dmemREN    in   1   data load request, held until dhit
//  dmemWEN    in   1   data store request, held until dhit
//  dmemaddr   in   32  data byte address
//  dmemstore  in   32  store data
//  ihit       out  1   1-cycle pulse: imemload valid
//  dhit       out  1   1-cycle pulse: load data valid / store done
//  imemload   out  32  fetched instruction (held until next ihit)
//  dmemload   out  32  loaded word (held until next load dhit)
//  ram_ren    out  1   RAM read strobe, held while access in flight
//  ram_wen    out  1   RAM write strobe, held while access in flight
//  ram_addr   out  32  word-aligned RAM address {addr[31:2],2'b00}
//  ram_wdata  out  32  RAM write data
//  ram_rdata  in   32  RAM read data, valid in ram_ack cycle
//  ram_ack    in   1   RAM access complete (1-cycle pulse)
//  mem_err    out  1   sticky: watchdog expired; cleared only by RST
// BEHAVIOUR
//  Reset:
//   - All outputs 0. FSM IDLE. Watchdog 0. IBUF invalid.
//  FSM states: IDLE, DACC, IACC, RESP.
//  IDLE:
//   - Data request (dmemREN|dmemWEN) has priority over imemREN.
//   - Latch addr/wdata/kind, drive ram_*, go DACC or IACC.
//   - Issue happens the same cycle the request is seen in IDLE.
//   - dmemWEN&dmemREN both set: treated as a store; REN ignored.
//  DACC/IACC:
//   - ram_* held from latched copies, not from live inputs.
//   - Watchdog increments every cycle.
//   - On ram_ack: capture ram_rdata into dmemload (loads) or imemload; go RESP.
//   - Stores leave dmemload unchanged.
//   - Watchdog reaches TIMEOUT with no ack: set mem_err, drop ram_*, go IDLE. No hit is issued.
//  RESP (1 cycle):
//   - Pulse dhit or ihit only if the originating request is still asserted with the same address.
//   - Otherwise the result is discarded silently. This covers a request dropped or re-addressed mid-access.
//   - Next state is always IDLE.
//  Latency:
//   - Hit = issue cycle + RAM latency + 1.
//   - With a 1-cycle RAM: request in cycle 0, ack in cycle 1, hit in cycle 2.
//  Fairness:
//   - Continuous data traffic may starve fetch. The datapath never does this (it stalls fetch during mem ops).
//   - ihit and dhit are never asserted in the same cycle.
//  ram_ack outside DACC/IACC is ignored.
//  RST mid-access: immediate return to IDLE. Outputs 0; imemload and dmemload cleared.
// CONFIGURATION
//  IBUF_EN:
//   - When defined, adds a one-entry instruction buffer {valid, tag[31:2], word}, filled on every IACC ack.
//   - In IDLE, a fetch with imemaddr[31:2]==tag and valid skips RAM: go RESP directly (hit 1 cycle after request).
//   - A store whose word address matches tag clears valid at issue.
//   - When undefined, every fetch goes to RAM.
// TESTING
//  - RAM latency 1, imemREN=1, imemaddr=0x0000_0004, ram_rdata=0x2001_0005 -> ram_addr=0x4 cycle 0; ihit cycle 2; imemload=0x2001_0005.
//  - imemREN and dmemREN both set, dmemaddr=0x0000_0100 -> RAM issues data first; dhit; then fetch issues; ihit later; never both hits in one cycle.
//  - dmemWEN=1, dmemaddr=0x0000_0203, dmemstore=0xDEAD_BEEF -> ram_wen=1, ram_addr=0x0000_0200, ram_wdata=0xDEAD_BEEF; dhit; dmemload unchanged.
//  - RAM never acks, TIMEOUT=64 -> ram_ren drops 64 cycles after issue; mem_err=1 stays until RST; no hit.
//  - imemaddr changes 0x4->0x8 mid-access -> no ihit for 0x4; next IDLE issues 0x8.
//  - IBUF_EN, fetch 0x10 twice -> second ihit 1 cycle after request, no ram_ren; then store 0x10, fetch 0x10 -> RAM access.

Source files
------------

// File: rtl/datapath_mem_responder_if.sv
// Datapath <-> memory responder bus, including the RAM side.
// master: datapath/RAM-model end; slave: the responder.
interface datapath_mem_responder_if;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        ihit;
    logic        dhit;
    logic [31:0] imemload;
    logic [31:0] dmemload;
    logic        ram_ren;
    logic        ram_wen;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        ram_ack;
    logic        mem_err;

    modport slave (
        input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, ram_rdata, ram_ack,
        output ihit, dhit, imemload, dmemload, ram_ren, ram_wen, ram_addr, ram_wdata, mem_err
    );
    modport master (
        output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, ram_rdata, ram_ack,
        input  ihit, dhit, imemload, dmemload, ram_ren, ram_wen, ram_addr, ram_wdata, mem_err
    );
endinterface

// File: rtl/datapath_mem_responder.sv
// Serves datapath fetch/load/store requests from a single-ported word RAM, with a hung-access watchdog.
// Optional IBUF_EN macro adds a one-entry instruction buffer in front of the RAM.
module datapath_mem_responder #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input logic CLK,
    input logic RST,
    datapath_mem_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, DACC, IACC, RESP} state_t;

    state_t             state;
    logic [CNT_W-1:0]   wd;
    logic [31:0]        lat_addr;
    logic [31:0]        lat_wdata;
    logic               lat_w;
    logic               lat_i;
    logic [31:0]        imemload_q;
    logic [31:0]        dmemload_q;
    logic               mem_err_q;
    logic               d_req;
    logic               ibuf_hit;
    logic               ren, wen;
    logic [31:0]        addr, wdata;

`ifdef IBUF_EN
    logic               ibuf_vld;
    logic [29:0]        ibuf_tag;
    logic [31:0]        ibuf_word;
    assign ibuf_hit = ibuf_vld && (bus.imemaddr[31:2] == ibuf_tag);
`else
    assign ibuf_hit = 1'b0;
`endif

    assign d_req = bus.dmemREN | bus.dmemWEN;

    // Issue is combinational in IDLE so the RAM sees the request in the same cycle.
    always_comb begin
        ren   = 1'b0;
        wen   = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
        case (state)
            IDLE: if (!RST) begin
                if (d_req) begin
                    wen   = bus.dmemWEN;
                    ren   = ~bus.dmemWEN;
                    addr  = {bus.dmemaddr[31:2], 2'b00};
                    wdata = bus.dmemWEN ? bus.dmemstore : 32'h0;
                end else if (bus.imemREN && !ibuf_hit) begin
                    ren  = 1'b1;
                    addr = {bus.imemaddr[31:2], 2'b00};
                end
            end
            DACC, IACC: begin
                ren   = ~lat_w;
                wen   = lat_w;
                addr  = {lat_addr[31:2], 2'b00};
                wdata = lat_w ? lat_wdata : 32'h0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            wd         <= '0;
            lat_addr   <= 32'h0;
            lat_wdata  <= 32'h0;
            lat_w      <= 1'b0;
            lat_i      <= 1'b0;
            imemload_q <= 32'h0;
            dmemload_q <= 32'h0;
            mem_err_q  <= 1'b0;
`ifdef IBUF_EN
            ibuf_vld   <= 1'b0;
            ibuf_tag   <= 30'h0;
            ibuf_word  <= 32'h0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (d_req) begin
                        lat_addr  <= bus.dmemaddr;
                        lat_wdata <= bus.dmemstore;
                        lat_w     <= bus.dmemWEN;
                        lat_i     <= 1'b0;
                        wd        <= CNT_W'(1);
                        state     <= DACC;
`ifdef IBUF_EN
                        if (bus.dmemWEN && bus.dmemaddr[31:2] == ibuf_tag)
                            ibuf_vld <= 1'b0;
`endif
                    end else if (bus.imemREN) begin
                        lat_addr <= bus.imemaddr;
                        lat_w    <= 1'b0;
                        lat_i    <= 1'b1;
                        if (ibuf_hit) begin
`ifdef IBUF_EN
                            imemload_q <= ibuf_word;
`endif
                            state <= RESP;
                        end else begin
                            wd    <= CNT_W'(1);
                            state <= IACC;
                        end
                    end
                end
                DACC, IACC: begin
                    if (bus.ram_ack) begin
                        if (state == IACC) begin
                            imemload_q <= bus.ram_rdata;
`ifdef IBUF_EN
                            ibuf_vld  <= 1'b1;
                            ibuf_tag  <= lat_addr[31:2];
                            ibuf_word <= bus.ram_rdata;
`endif
                        end else if (!lat_w) begin
                            dmemload_q <= bus.ram_rdata;
                        end
                        wd    <= '0;
                        state <= RESP;
                    end else if (wd == CNT_W'(TIMEOUT - 1)) begin
                        // wd counts the issue cycle, so strobes drop TIMEOUT cycles after issue
                        mem_err_q <= 1'b1;
                        wd        <= '0;
                        state     <= IDLE;
                    end else begin
                        wd <= wd + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A hit is only reported if the datapath still wants exactly what was fetched.
    assign bus.ihit = (state == RESP) && lat_i && bus.imemREN && (bus.imemaddr == lat_addr);
    assign bus.dhit = (state == RESP) && !lat_i && (bus.dmemaddr == lat_addr) &&
                      (lat_w ? bus.dmemWEN : (bus.dmemREN && !bus.dmemWEN));

    assign bus.ram_ren   = ren;
    assign bus.ram_wen   = wen;
    assign bus.ram_addr  = addr;
    assign bus.ram_wdata = wdata;
    assign bus.imemload  = imemload_q;
    assign bus.dmemload  = dmemload_q;
    assign bus.mem_err   = mem_err_q;
endmodule

// File: tb/tb_datapath_mem_responder.sv
// Directed bench for datapath_mem_responder: vector table plus hand-written multi-cycle sequences.
module tb_datapath_mem_responder;
    logic clk, rst;
    int   n_cmp, n_err;
    bit   ack_en;
    logic [31:0] mem [256];

    datapath_mem_responder_if bus();
    datapath_mem_responder #(.TIMEOUT(64), .CNT_W(7)) dut (.CLK(clk), .RST(rst), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0] K_F = 2'd0, K_L = 2'd1, K_S = 2'd2, K_SL = 2'd3;
    typedef struct {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_ram;
        int          exp_lat;
        logic [31:0] exp_data;
    } vec_t;
    vec_t tbl [7];

    // RAM model: acks one cycle after it sees a strobe.
    always begin : ram_model
        bit          hold, hw;
        logic [31:0] haddr, hwd;
        @(negedge clk);
        hold  = (bus.ram_ren || bus.ram_wen) && ack_en && !bus.ram_ack;
        hw    = bus.ram_wen;
        haddr = bus.ram_addr;
        hwd   = bus.ram_wdata;
        @(posedge clk); #1;
        bus.ram_ack   = hold;
        bus.ram_rdata = hold ? mem[haddr[9:2]] : 32'h0;
        if (hold && hw) mem[haddr[9:2]] = hwd;
    end

    always @(negedge clk) if (bus.ihit && bus.dhit) begin
        n_err++;
        $display("FAIL both_hits: ihit=1 dhit=1 expected at most one");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drop_all();
        bus.imemREN = 0; bus.dmemREN = 0; bus.dmemWEN = 0;
    endtask

    task automatic run_txn(input vec_t v, input string nm);
        int lat;
        bit got, st;
        st = (v.kind == K_S) || (v.kind == K_SL);
        tick();
        case (v.kind)
            K_F:  begin bus.imemREN = 1; bus.imemaddr = v.addr; end
            K_L:  begin bus.dmemREN = 1; bus.dmemaddr = v.addr; end
            K_S:  begin bus.dmemWEN = 1; bus.dmemaddr = v.addr; bus.dmemstore = v.wdata; end
            default: begin bus.dmemWEN = 1; bus.dmemREN = 1; bus.dmemaddr = v.addr; bus.dmemstore = v.wdata; end
        endcase
        @(negedge clk);
        if (v.exp_lat == 1) chk({nm, "_nostrobe"}, {31'h0, bus.ram_ren | bus.ram_wen}, 32'h0);
        else begin
            chk({nm, "_ram_addr"}, bus.ram_addr, v.exp_ram);
            chk({nm, "_ram_ren"}, {31'h0, bus.ram_ren}, {31'h0, !st});
            chk({nm, "_ram_wen"}, {31'h0, bus.ram_wen}, {31'h0, st});
            if (st) chk({nm, "_ram_wdata"}, bus.ram_wdata, v.wdata);
        end
        lat = 0; got = 0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            got = (v.kind == K_F) ? bus.ihit : bus.dhit;
        end
        chk({nm, "_latency"}, 32'(lat), 32'(v.exp_lat));
        chk({nm, "_data"}, (v.kind == K_F) ? bus.imemload : bus.dmemload, v.exp_data);
        tick();
        drop_all();
    endtask

    initial begin
        int icyc, dcyc, rdrop, ecyc, hits;
        vec_t v;
        n_cmp = 0; n_err = 0; ack_en = 1;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[1] = 32'h2001_0005; mem[2] = 32'h8C41_0000; mem[3] = 32'h0000_0020;
        mem[4] = 32'hAC22_0004; mem[5] = 32'h1111_2222; mem[8'h40] = 32'h1234_5678;
        bus.imemREN = 0; bus.imemaddr = 0; bus.dmemREN = 0; bus.dmemWEN = 0;
        bus.dmemaddr = 0; bus.dmemstore = 0; bus.ram_rdata = 0; bus.ram_ack = 0;

        tbl[0] = '{K_F,  32'h0000_0004, 32'h0,          32'h0000_0004, 2, 32'h2001_0005};
        tbl[1] = '{K_L,  32'h0000_0100, 32'h0,          32'h0000_0100, 2, 32'h1234_5678};
        tbl[2] = '{K_S,  32'h0000_0203, 32'hDEAD_BEEF, 32'h0000_0200, 2, 32'h1234_5678};
        tbl[3] = '{K_L,  32'h0000_0202, 32'h0,          32'h0000_0200, 2, 32'hDEAD_BEEF};
        tbl[4] = '{K_F,  32'h0000_0008, 32'h0,          32'h0000_0008, 2, 32'h8C41_0000};
        tbl[5] = '{K_SL, 32'h0000_0104, 32'hCAFE_F00D, 32'h0000_0104, 2, 32'hDEAD_BEEF};
        tbl[6] = '{K_L,  32'h0000_0104, 32'h0,          32'h0000_0104, 2, 32'hCAFE_F00D};

        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ram_ren", {31'h0, bus.ram_ren}, 32'h0);
        chk("rst_hits", {30'h0, bus.ihit, bus.dhit}, 32'h0);
        tick(); rst = 0;
        @(negedge clk);
        chk("rst_imemload", bus.imemload, 32'h0);
        chk("rst_dmemload", bus.dmemload, 32'h0);
        chk("rst_mem_err", {31'h0, bus.mem_err}, 32'h0);
        chk("rst_strobes", {30'h0, bus.ram_ren, bus.ram_wen}, 32'h0);

        for (int i = 0; i < 7; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

        // Simultaneous fetch and load: data first, fetch re-issues after RESP.
        tick();
        bus.imemREN = 1; bus.imemaddr = 32'hC; bus.dmemREN = 1; bus.dmemaddr = 32'h100;
        icyc = -1; dcyc = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 0) chk("prio_ram_addr", bus.ram_addr, 32'h100);
            if (bus.dhit && dcyc < 0) dcyc = c;
            if (bus.ihit && icyc < 0) icyc = c;
            tick();
            if (dcyc >= 0) bus.dmemREN = 0;
            if (icyc >= 0) bus.imemREN = 0;
        end
        chk("prio_dhit_cyc", 32'(dcyc), 32'd2);
        chk("prio_ihit_cyc", 32'(icyc), 32'd5);
        chk("prio_dmemload", bus.dmemload, 32'h1234_5678);
        chk("prio_imemload", bus.imemload, 32'h0000_0020);

        // Fetch re-addressed mid-access: first result discarded.
        tick();
        bus.imemREN = 1; bus.imemaddr = 32'h4;
        icyc = -1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c == 3) chk("readdr_issue", bus.ram_addr, 32'h8);
            if (bus.ihit && icyc < 0) icyc = c;
            tick();
            if (c == 0) bus.imemaddr = 32'h8;
            if (icyc >= 0) bus.imemREN = 0;
        end
        chk("readdr_ihit_cyc", 32'(icyc), 32'd5);
        chk("readdr_imemload", bus.imemload, 32'h8C41_0000);

        // Hung RAM: watchdog aborts after TIMEOUT cycles.
        ack_en = 0;
        tick();
        bus.dmemREN = 1; bus.dmemaddr = 32'h100;
        rdrop = -1; ecyc = -1; hits = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (!bus.ram_ren && rdrop < 0) rdrop = c;
            if (bus.mem_err && ecyc < 0) ecyc = c;
            if (bus.ihit || bus.dhit) hits++;
            tick();
            if (c == 59) bus.dmemREN = 0;
        end
        chk("wd_ren_drop_cyc", 32'(rdrop), 32'd64);
        chk("wd_err_cyc", 32'(ecyc), 32'd64);
        chk("wd_no_hit", 32'(hits), 32'd0);
        ack_en = 1;
        v = '{K_F, 32'h14, 32'h0, 32'h14, 2, 32'h1111_2222};
        run_txn(v, "post_wd");
        @(negedge clk);
        chk("wd_err_sticky", {31'h0, bus.mem_err}, 32'h1);

        // Reset in the middle of a fetch.
        tick();
        bus.imemREN = 1; bus.imemaddr = 32'h4;
        @(negedge clk);
        tick(); rst = 1;
        @(negedge clk);
        chk("rstmid_ram_ren", {31'h0, bus.ram_ren}, 32'h0);
        chk("rstmid_mem_err", {31'h0, bus.mem_err}, 32'h0);
        chk("rstmid_imemload", bus.imemload, 32'h0);
        chk("rstmid_dmemload", bus.dmemload, 32'h0);
        tick(); drop_all(); rst = 0;
        repeat (2) tick();

        // Repeated fetch: buffered when the instruction buffer is built in.
        v = '{K_F, 32'h10, 32'h0, 32'h10, 2, 32'hAC22_0004};
        run_txn(v, "rep_fetch1");
`ifdef IBUF_EN
        v.exp_lat = 1;
`endif
        run_txn(v, "rep_fetch2");
        v = '{K_S, 32'h10, 32'h5555_AAAA, 32'h10, 2, 32'h0};
        run_txn(v, "rep_store");
        v = '{K_F, 32'h10, 32'h0, 32'h10, 2, 32'h5555_AAAA};
        run_txn(v, "rep_fetch3");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
